// File: rtl/halut_pkg.sv
// -----------------------------------------------------------------------------
// halut_pkg
// Shared configuration and helpers for the HALUT encoder/decoder blocks.
//   C, K       : codebook count and prototypes per codebook (K is a power of 2)
//   Fp16Width  : width of an FP16 scalar
//   fp16_t     : raw FP16 bit pattern
//   fp16_gt()  : sign-magnitude "greater than" on FP16 bit patterns
// -----------------------------------------------------------------------------
package halut_pkg;

  localparam int C         = 32;
  localparam int K         = 16;
  localparam int Fp16Width = 16;

  typedef logic [15:0] fp16_t;

  // Sign-magnitude compare. Both zeros are equal regardless of sign; NaN/Inf
  // are not special-cased and simply order by their magnitude bits.
  function automatic logic fp16_gt(fp16_t a, fp16_t b);
    logic a_zero;
    logic b_zero;
    logic gt;
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    if (a_zero && b_zero) begin
      gt = 1'b0;
    end else if (a[15] != b[15]) begin
      // Signs differ: a is greater exactly when b is the negative one.
      gt = b[15];
    end else if (a[15] == 1'b0) begin
      gt = (a[14:0] > b[14:0]);
    end else begin
      // Both negative: larger magnitude means smaller value.
      gt = (a[14:0] < b[14:0]);
    end
    return gt;
  endfunction

endpackage

// File: rtl/halut_encoder_stage.sv
// -----------------------------------------------------------------------------
// halut_encoder_stage
// One level of the pipelined decision-tree walk. Compares this level's feature
// against the threshold of the current heap node, appends the result to the
// partial path and registers valid / codebook / path / features for the next
// level.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous flush of the valid bit
//   valid_i, c_i, idx_i, a_i : beat arriving at this level (idx_i holds Level bits)
//   node_o        : heap node read by this level (combinational)
//   thr_i         : threshold T[c_i][node_o] returned by the register file
//   valid_o, c_o, idx_o, a_o : registered beat for the next level
// -----------------------------------------------------------------------------
module halut_encoder_stage
  import halut_pkg::*;
#(
  parameter int Level      = 0,
  parameter int TreeDepth  = 4,
  parameter int CAddrWidth = 5
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            valid_i,
  input  logic [CAddrWidth-1:0]           c_i,
  input  logic [TreeDepth-1:0]            idx_i,
  input  logic [TreeDepth*Fp16Width-1:0]  a_i,
  input  logic [Fp16Width-1:0]            thr_i,
  output logic [TreeDepth-1:0]            node_o,
  output logic                            valid_o,
  output logic [CAddrWidth-1:0]           c_o,
  output logic [TreeDepth-1:0]            idx_o,
  output logic [TreeDepth*Fp16Width-1:0]  a_o
);

  // Heap offset of this level's first node; also the mask of the Level valid
  // path bits (only Level bits of idx_i are meaningful, zero at level 0).
  localparam logic [TreeDepth-1:0] NodeBase = TreeDepth'((1 << Level) - 1);
  localparam logic [TreeDepth-1:0] IdxMask  = TreeDepth'((1 << Level) - 1);

  logic [TreeDepth-1:0]           idx_s;
  fp16_t                          feat_s;
  logic                           bit_s;

  logic                           valid_q, valid_d;
  logic [CAddrWidth-1:0]          c_q, c_d;
  logic [TreeDepth-1:0]           idx_q, idx_d;
  logic [TreeDepth*Fp16Width-1:0] a_q, a_d;

  assign idx_s  = idx_i & IdxMask;
  assign node_o = NodeBase + idx_s;
  assign feat_s = a_i[Level*Fp16Width +: Fp16Width];
  assign bit_s  = fp16_gt(feat_s, thr_i);

  // Next-state: flush kills the valid bit; bubbles hold the data registers.
  always_comb begin
    valid_d = valid_q;
    c_d     = c_q;
    idx_d   = idx_q;
    a_d     = a_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_i;
      if (valid_i) begin
        c_d   = c_i;
        idx_d = (idx_s << 1) | TreeDepth'(bit_s);
        a_d   = a_i;
      end else begin
        c_d   = c_q;
        idx_d = idx_q;
        a_d   = a_q;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      c_q     <= {CAddrWidth{1'b0}};
      idx_q   <= {TreeDepth{1'b0}};
      a_q     <= {(TreeDepth*Fp16Width){1'b0}};
    end else begin
      valid_q <= valid_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
    end
  end

  assign valid_o = valid_q;
  assign c_o     = c_q;
  assign idx_o   = idx_q;
  assign a_o     = a_q;

endmodule

// File: rtl/halut_encoder.sv
// -----------------------------------------------------------------------------
// halut_encoder
// Maddness-style tree encoder. Each accepted beat is tagged with the running
// codebook counter and walked through TreeDepth pipelined tree levels; the
// resulting prototype index streams straight into the HALUT decoder.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   waddr_i/wdata_i/we_i : threshold write port, address {c, node}
//   encoder_i            : run enable; low flushes and clears the error flag
//   valid_i, a_i         : feature beat, a_i[l] = a_i[l*16 +: 16] for level l
//   c_addr_o, k_addr_o   : codebook / prototype index to the decoder
//   decoder_o            : stream valid to the decoder
//   err_o                : sticky mid-row gap indicator
// -----------------------------------------------------------------------------
module halut_encoder
  import halut_pkg::*;
#(
  parameter int C              = halut_pkg::C,
  parameter int K              = halut_pkg::K,
  parameter int CAddrWidth     = $clog2(C),
  parameter int TreeDepth      = $clog2(K),
  parameter int TotalAddrWidth = $clog2(C*K)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [TotalAddrWidth-1:0]      waddr_i,
  input  logic [15:0]                    wdata_i,
  input  logic                           we_i,
  input  logic                           encoder_i,
  input  logic                           valid_i,
  input  logic [TreeDepth*16-1:0]        a_i,
  output logic [CAddrWidth-1:0]          c_addr_o,
  output logic [TreeDepth-1:0]           k_addr_o,
  output logic                           decoder_o,
  output logic                           err_o
);

  // Threshold register file: node K-1 of each codebook has no storage.
  logic [Fp16Width-1:0] thr_q [C][K-1];

  logic [CAddrWidth-1:0] wr_c_s;
  logic [TreeDepth-1:0]  wr_node_s;

  logic [CAddrWidth-1:0] c_in_q, c_in_d;
  logic                  err_q, err_d;
  logic                  accept_s;

  // Pipeline chain: index l feeds stage l, index TreeDepth is the output.
  logic                           valid_s [TreeDepth+1];
  logic [CAddrWidth-1:0]          c_s     [TreeDepth+1];
  logic [TreeDepth-1:0]           idx_s   [TreeDepth+1];
  logic [TreeDepth*Fp16Width-1:0] feat_s  [TreeDepth+1];

  assign wr_c_s    = waddr_i[TotalAddrWidth-1 -: CAddrWidth];
  assign wr_node_s = waddr_i[TreeDepth-1:0];
  assign accept_s  = encoder_i & valid_i;

  // Threshold writes; reads are combinational so a same-cycle read sees the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ci = 0; ci < C; ci++) begin
        for (int ni = 0; ni < K-1; ni++) begin
          thr_q[ci][ni] <= {Fp16Width{1'b0}};
        end
      end
    end else if (we_i && (wr_node_s != TreeDepth'(K-1))) begin
      thr_q[wr_c_s][wr_node_s] <= wdata_i;
    end
  end

  // Codebook counter and sticky gap flag. A missing beat mid-row freezes the
  // counter so the decoder sees a bubble rather than a skipped codebook.
  always_comb begin
    c_in_d = c_in_q;
    err_d  = err_q;
    if (!encoder_i) begin
      c_in_d = {CAddrWidth{1'b0}};
      err_d  = 1'b0;
    end else if (valid_i) begin
      if (c_in_q == CAddrWidth'(C-1)) begin
        c_in_d = {CAddrWidth{1'b0}};
      end else begin
        c_in_d = c_in_q + {{(CAddrWidth-1){1'b0}}, 1'b1};
      end
    end else if (c_in_q != {CAddrWidth{1'b0}}) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Counter and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_in_q <= {CAddrWidth{1'b0}};
      err_q  <= 1'b0;
    end else begin
      c_in_q <= c_in_d;
      err_q  <= err_d;
    end
  end

  assign valid_s[0] = accept_s;
  assign c_s[0]     = c_in_q;
  assign idx_s[0]   = {TreeDepth{1'b0}};
  assign feat_s[0]  = a_i;

  for (genvar l = 0; l < TreeDepth; l++) begin : g_stage
    logic [TreeDepth-1:0] node_s;
    fp16_t                thr_s;

    assign thr_s = thr_q[c_s[l]][node_s];

    halut_encoder_stage #(
      .Level      (l),
      .TreeDepth  (TreeDepth),
      .CAddrWidth (CAddrWidth)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (~encoder_i),
      .valid_i (valid_s[l]),
      .c_i     (c_s[l]),
      .idx_i   (idx_s[l]),
      .a_i     (feat_s[l]),
      .thr_i   (thr_s),
      .node_o  (node_s),
      .valid_o (valid_s[l+1]),
      .c_o     (c_s[l+1]),
      .idx_o   (idx_s[l+1]),
      .a_o     (feat_s[l+1])
    );
  end

  assign c_addr_o  = c_s[TreeDepth];
  assign k_addr_o  = idx_s[TreeDepth];
  assign decoder_o = valid_s[TreeDepth];
  assign err_o     = err_q;

endmodule

// File: tb/tb_halut_encoder.sv
// -----------------------------------------------------------------------------
// tb_halut_encoder
// Directed self-checking bench for halut_encoder with C=32, K=16 (depth 4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// a beat driven in loop iteration n shows up on the outputs in iteration n+3.
// -----------------------------------------------------------------------------
module tb_halut_encoder;
  import halut_pkg::*;

  localparam int D  = 4;
  localparam int CW = 5;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] waddr;
  logic [15:0]   wdata;
  logic          we;
  logic          enc;
  logic          valid;
  logic [D*16-1:0] a;
  logic [CW-1:0] c_addr;
  logic [D-1:0]  k_addr;
  logic          dec;
  logic          err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  halut_encoder dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .we_i      (we),
    .encoder_i (enc),
    .valid_i   (valid),
    .a_i       (a),
    .c_addr_o  (c_addr),
    .k_addr_o  (k_addr),
    .decoder_o (dec),
    .err_o     (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_thr(input int c, input int node, input logic [15:0] v);
    waddr = AW'(c * 16 + node);
    wdata = v;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; enc = 1'b0; valid = 1'b0; a = '0; waddr = '0; wdata = '0;
    #12;
    checks++; if (dec !== 1'b0) begin fails++; $display("FAIL reset_dec got %b want 0", dec); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (c_addr !== 5'd0) begin fails++; $display("FAIL reset_c got %0d want 0", c_addr); end
    checks++; if (k_addr !== 4'd0) begin fails++; $display("FAIL reset_k got %0d want 0", k_addr); end
    tick();
    rst_n = 1'b1;
    enc   = 1'b1;
    tick();
  endtask

  // +1.0 on every level against all-zero thresholds: every compare is true.
  task automatic test_all_positive();
    a = {4{16'h3C00}};
    for (int cyc = 0; cyc < 35; cyc++) begin
      valid = (cyc < 32);
      tick();
      if (cyc == 2) begin
        checks++; if (dec !== 1'b0) begin fails++; $display("FAIL latency_early got %b want 0", dec); end
      end
      if (cyc >= 3) begin
        checks++; if (dec !== 1'b1) begin fails++; $display("FAIL pos_dec beat %0d got %b want 1", cyc-3, dec); end
        checks++; if (c_addr !== CW'(cyc-3)) begin fails++; $display("FAIL pos_c got %0d want %0d", c_addr, cyc-3); end
        checks++; if (k_addr !== 4'd15) begin fails++; $display("FAIL pos_k beat %0d got %0d want 15", cyc-3, k_addr); end
      end
    end
    valid = 1'b0;
    tick();
    checks++; if (dec !== 1'b0) begin fails++; $display("FAIL pos_tail_dec got %b want 0", dec); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL pos_tail_err got %b want 0", err); end
  endtask

  // Row of -1.0 followed by a row of -0.0: neither is greater than +0.
  task automatic test_negative();
    for (int cyc = 0; cyc < 67; cyc++) begin
      valid = (cyc < 64);
      a = (cyc < 32) ? {4{16'hBC00}} : {4{16'h8000}};
      tick();
      if (cyc >= 3) begin
        checks++; if (dec !== 1'b1) begin fails++; $display("FAIL neg_dec beat %0d got %b want 1", cyc-3, dec); end
        checks++; if (k_addr !== 4'd0) begin fails++; $display("FAIL neg_k beat %0d got %0d want 0", cyc-3, k_addr); end
      end
    end
    valid = 1'b0;
    tick();
  endtask

  // c=5: node0=2.0, node2=0.5; features {3.0, 0.6, -1, -1} -> path 1,1,0,0.
  task automatic test_program();
    wr_thr(5, 0, 16'h4000);
    wr_thr(5, 2, 16'h3800);
    for (int cyc = 0; cyc < 35; cyc++) begin
      valid = (cyc < 32);
      a = (cyc == 5) ? {16'hBC00, 16'hBC00, 16'h38CD, 16'h4200} : {4{16'h3C00}};
      tick();
      if (cyc >= 3) begin
        checks++;
        if (k_addr !== ((cyc == 8) ? 4'b1100 : 4'd15)) begin
          fails++; $display("FAIL prog_k beat %0d got %b", cyc-3, k_addr);
        end
      end
    end
    valid = 1'b0;
    tick();
    wr_thr(5, 0, 16'h0000);
    wr_thr(5, 2, 16'h0000);
  endtask

  task automatic test_back_to_back();
    a = {4{16'h3C00}};
    for (int cyc = 0; cyc < 67; cyc++) begin
      valid = (cyc < 64);
      tick();
      if (cyc >= 3) begin
        checks++; if (dec !== 1'b1) begin fails++; $display("FAIL b2b_dec beat %0d got %b want 1", cyc-3, dec); end
        checks++; if (c_addr !== CW'((cyc-3) % 32)) begin fails++; $display("FAIL b2b_c got %0d want %0d", c_addr, (cyc-3) % 32); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err got %b want 0", err); end
      end
    end
    valid = 1'b0;
    tick();
  endtask

  // Gap at c=10: counter holds, bubble propagates, sticky error until flush.
  task automatic test_error();
    logic vexp;
    a = {4{16'h3C00}};
    for (int cyc = 0; cyc < 18; cyc++) begin
      valid = (cyc <= 14) && (cyc != 10);
      tick();
      checks++; if (err !== (cyc >= 10)) begin fails++; $display("FAIL gap_err cyc %0d got %b want %b", cyc, err, cyc >= 10); end
      if (cyc >= 3) begin
        vexp = (cyc - 3 <= 14) && (cyc - 3 != 10);
        checks++; if (dec !== vexp) begin fails++; $display("FAIL gap_dec cyc %0d got %b want %b", cyc, dec, vexp); end
        if (vexp) begin
          checks++;
          if (c_addr !== CW'((cyc - 3 < 10) ? (cyc - 3) : (cyc - 4))) begin
            fails++; $display("FAIL gap_c cyc %0d got %0d", cyc, c_addr);
          end
        end
      end
    end
    valid = 1'b0;
    enc   = 1'b0;
    tick();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL flush_err got %b want 0", err); end
    checks++; if (dec !== 1'b0) begin fails++; $display("FAIL flush_dec got %b want 0", dec); end
    enc = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      valid = (cyc == 0);
      tick();
      checks++; if (dec !== (cyc == 3)) begin fails++; $display("FAIL restart_dec cyc %0d got %b", cyc, dec); end
    end
    checks++; if (c_addr !== 5'd0) begin fails++; $display("FAIL restart_c got %0d want 0", c_addr); end
    enc = 1'b0;
    tick();
    enc = 1'b1;
  endtask

  // Same-cycle write/read returns the old value; next-level reads see the new one.
  task automatic test_write_hazard();
    logic [3:0] kexp;
    a = {4{16'h3C00}};
    for (int cyc = 0; cyc < 67; cyc++) begin
      valid = (cyc < 64);
      we    = (cyc < 2);
      waddr = (cyc == 0) ? AW'(0 * 16 + 2) : AW'(1 * 16 + 0);
      wdata = 16'h4000;
      tick();
      if (cyc >= 3) begin
        if ((cyc - 3) % 32 == 0)      kexp = 4'd11;
        else if ((cyc - 3) == 1)      kexp = 4'd15;
        else if ((cyc - 3) == 33)     kexp = 4'd7;
        else                          kexp = 4'd15;
        checks++; if (k_addr !== kexp) begin fails++; $display("FAIL hazard_k beat %0d got %0d want %0d", cyc-3, k_addr, kexp); end
      end
    end
    we    = 1'b0;
    valid = 1'b0;
    tick();
    wr_thr(0, 2, 16'h0000);
    wr_thr(1, 0, 16'h0000);
  endtask

  // Asynchronous reset mid-row drops the stream at once and emits nothing after.
  task automatic test_async_reset();
    a = {4{16'h3C00}};
    valid = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) tick();
    checks++; if (dec !== 1'b1) begin fails++; $display("FAIL pre_rst_dec got %b want 1", dec); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dec !== 1'b0) begin fails++; $display("FAIL async_rst_dec got %b want 0", dec); end
    checks++; if (c_addr !== 5'd0) begin fails++; $display("FAIL async_rst_c got %0d want 0", c_addr); end
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      checks++; if (dec !== 1'b0) begin fails++; $display("FAIL post_rst_dec cyc %0d got %b want 0", cyc, dec); end
    end
  endtask

  initial begin
    test_reset();
    test_all_positive();
    test_negative();
    test_program();
    test_back_to_back();
    test_error();
    test_write_hazard();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
